// File: rtl/arm_lsu_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arm_lsu_if: core request/response and data-memory bus signals.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface arm_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] memaddr;
  logic              memread;
  logic              memwrite;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              mem_ready;

  // master = core plus memory environment, slave = the LSU itself
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           readdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           memaddr, memread, memwrite, be, writedata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           readdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           memaddr, memread, memwrite, be, writedata
  );
endinterface
`default_nettype wire

// File: rtl/arm_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arm_lsu: size-aware load/store unit between core and data bus.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module arm_lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic      clk,
  input  logic      reset,
  arm_lsu_if.slave  bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] c_addr_mask = ~ADDR_W'(BE_W - 1);
  localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_memaddr;
  logic              r_memread;
  logic              r_memwrite;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_writedata;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [OFF_W-1:0]  r_off;

  logic [2:0]        w_align_mask;
  logic [BE_W-1:0]   w_be_base;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata_rep;
  logic [OFF_W-1:0]  w_off;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_timeout;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_mask;
  logic              w_sign;
  logic [DATA_W-1:0] w_load;

  // Request decode: lane enables, store replication and alignment mask
  always_comb begin
    w_align_mask = 3'b000;
    w_be_base    = '0;
    w_wdata_rep  = '0;
    case (bus.req_size)
      2'd0: begin
        w_align_mask = 3'b000;
        w_be_base    = BE_W'(8'h01);
        w_wdata_rep  = {(DATA_W/8){bus.req_wdata[7:0]}};
      end
      2'd1: begin
        w_align_mask = 3'b001;
        w_be_base    = BE_W'(8'h03);
        w_wdata_rep  = {(DATA_W/16){bus.req_wdata[15:0]}};
      end
      2'd2: begin
        w_align_mask = 3'b011;
        w_be_base    = BE_W'(8'h0F);
        w_wdata_rep  = {(DATA_W/32){bus.req_wdata[31:0]}};
      end
      default: begin
        w_align_mask = 3'b111;
        w_be_base    = BE_W'(8'hFF);
        w_wdata_rep  = bus.req_wdata;
      end
    endcase
  end

  assign w_off        = bus.req_addr[OFF_W-1:0];
  assign w_be         = w_be_base << w_off;
  assign w_illegal    = (bus.req_size == 2'd3) && (DATA_W != 64);
  assign w_misaligned = |(bus.req_addr[2:0] & w_align_mask);
  assign w_timeout    = (TIMEOUT != 0) && (r_cnt == c_cnt_last);

  // Load path: shift the addressed lane down, mask to size, then extend
  assign w_shift = bus.readdata >> {r_off, 3'b000};

  always_comb begin
    w_mask = '1;
    w_sign = 1'b0;
    case (r_size)
      2'd0: begin
        w_mask = DATA_W'(8'hFF);
        w_sign = w_shift[7];
      end
      2'd1: begin
        w_mask = DATA_W'(16'hFFFF);
        w_sign = w_shift[15];
      end
      2'd2: begin
        w_mask = DATA_W'(32'hFFFF_FFFF);
        w_sign = w_shift[31];
      end
      default: begin
        w_mask = '1;
        w_sign = 1'b0;
      end
    endcase
    w_load = w_shift & w_mask;
    if (r_signed && w_sign) begin
      w_load = w_load | ~w_mask;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_memaddr   <= '0;
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
      r_be        <= '0;
      r_writedata <= '0;
      r_cnt       <= '0;
      r_size      <= 2'd0;
      r_signed    <= 1'b0;
      r_off       <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (w_illegal || w_misaligned) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state     <= S_ACCESS;
              r_size      <= bus.req_size;
              r_signed    <= bus.req_signed;
              r_off       <= w_off;
              r_cnt       <= '0;
              r_memaddr   <= bus.req_addr & c_addr_mask;
              r_be        <= w_be;
              r_writedata <= bus.req_write ? w_wdata_rep : '0;
              r_memread   <= !bus.req_write;
              r_memwrite  <= bus.req_write;
            end
          end
        end
        S_ACCESS: begin
          // A ready in the final counted cycle still completes successfully
          if (bus.mem_ready) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_memread ? w_load : '0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_be        <= '0;
          end else if (w_timeout) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_be        <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.memaddr   = r_memaddr;
  assign bus.memread   = r_memread;
  assign bus.memwrite  = r_memwrite;
  assign bus.be        = r_be;
  assign bus.writedata = r_writedata;

endmodule
`default_nettype wire

// File: tb/tb_arm_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_arm_lsu: vector table plus scoreboard bench for arm_lsu.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_arm_lsu;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic clk;
  logic reset;

  arm_lsu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  arm_lsu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    int          cycles;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rdata_exp;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waits, input int cycles,
                              input logic [3:0] be, input logic [31:0] maddr,
                              input logic [31:0] wd, input logic err,
                              input logic [31:0] rdata_exp);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.waits = waits; v.cycles = cycles; v.be = be;
    v.maddr = maddr; v.wd = wd; v.err = err; v.rdata_exp = rdata_exp;
    return v;
  endfunction

  // Response scoreboard and bus invariants, sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      if (bus.memread && bus.memwrite) chk("strobe_excl", 1, 0);
      if (!bus.memread && !bus.memwrite && bus.be != 4'h0) chk("be_idle", {60'h0, bus.be}, 0);
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_err", bus.rsp_err, e.err);
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int hi;
    bit done;
    exp_t e;
    @(negedge clk);
    chk("req_ready", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_write  = v.wr;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    e.err = v.err;
    e.rdata = v.rdata_exp;
    exp_q.push_back(e);
    @(negedge clk);
    // garbage on req_* must be ignored once the request is accepted
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_size  = 2'($urandom);
    hi = 0;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      if (bus.memread || bus.memwrite) begin
        hi++;
        chk("memread", bus.memread, !v.wr);
        chk("memwrite", bus.memwrite, v.wr);
        chk("be", bus.be, v.be);
        chk("memaddr", bus.memaddr, v.maddr);
        if (v.wr) chk("writedata", bus.writedata, v.wd);
        bus.mem_ready = (hi == v.waits + 1);
        bus.readdata  = bus.mem_ready ? v.rdata : $urandom;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    bus.mem_ready = 1'b0;
    if (!done) chk("bus_timeout", 1, 0);
    chk("strobe_cycles", hi, v.cycles);
    chk("rsp_valid", bus.rsp_valid, 1);
    @(negedge clk);
    chk("rsp_pulse", bus.rsp_valid, 0);
  endtask

  vec_t vecs[14];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            wr    sz    sg    addr       wdata          rdata          wt  cy be     maddr      wd             err   rdata_exp
    vecs[0]  = mk(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00AB, 32'h0,         0,  1, 4'h8, 32'h100, 32'hABAB_ABAB, 1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 2'd1, 1'b1, 32'h202, 32'h0,         32'h8001_0000, 0,  1, 4'hC, 32'h200, 32'h0,         1'b0, 32'hFFFF_8001);
    vecs[2]  = mk(1'b0, 2'd1, 1'b0, 32'h202, 32'h0,         32'h8001_0000, 0,  1, 4'hC, 32'h200, 32'h0,         1'b0, 32'h0000_8001);
    vecs[3]  = mk(1'b0, 2'd2, 1'b0, 32'h301, 32'h0,         32'h0,         0,  0, 4'h0, 32'h0,   32'h0,         1'b1, 32'h0);
    vecs[4]  = mk(1'b0, 2'd2, 1'b0, 32'h300, 32'h0,         32'h0,         255, 4, 4'hF, 32'h300, 32'h0,        1'b1, 32'h0);
    vecs[5]  = mk(1'b0, 2'd2, 1'b0, 32'h400, 32'h0,         32'hDEAD_BEEF, 3,  4, 4'hF, 32'h400, 32'h0,         1'b0, 32'hDEAD_BEEF);
    vecs[6]  = mk(1'b1, 2'd1, 1'b0, 32'h012, 32'h1234_5678, 32'h0,         1,  2, 4'hC, 32'h010, 32'h5678_5678, 1'b0, 32'h0);
    vecs[7]  = mk(1'b0, 2'd0, 1'b1, 32'h041, 32'h0,         32'h0000_8000, 0,  1, 4'h2, 32'h040, 32'h0,         1'b0, 32'hFFFF_FF80);
    vecs[8]  = mk(1'b0, 2'd0, 1'b1, 32'h043, 32'h0,         32'h7F00_0000, 2,  3, 4'h8, 32'h040, 32'h0,         1'b0, 32'h0000_007F);
    vecs[9]  = mk(1'b0, 2'd3, 1'b0, 32'h000, 32'h0,         32'h0,         0,  0, 4'h0, 32'h0,   32'h0,         1'b1, 32'h0);
    vecs[10] = mk(1'b1, 2'd1, 1'b0, 32'h013, 32'h0000_BEEF, 32'h0,         0,  0, 4'h0, 32'h0,   32'h0,         1'b1, 32'h0);
    vecs[11] = mk(1'b1, 2'd2, 1'b0, 32'h020, 32'hCAFE_F00D, 32'h0,         2,  3, 4'hF, 32'h020, 32'hCAFE_F00D, 1'b0, 32'h0);
    vecs[12] = mk(1'b0, 2'd2, 1'b1, 32'h050, 32'h0,         32'h8000_0000, 0,  1, 4'hF, 32'h050, 32'h0,         1'b0, 32'h8000_0000);
    vecs[13] = mk(1'b0, 2'd1, 1'b0, 32'h060, 32'h0,         32'hFFFF_1234, 0,  1, 4'h3, 32'h060, 32'h0,         1'b0, 32'h0000_1234);

    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.readdata   = '0;
    bus.mem_ready  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_memread", bus.memread, 0);
    chk("rst_memwrite", bus.memwrite, 0);
    chk("rst_be", bus.be, 0);
    chk("rst_memaddr", bus.memaddr, 0);
    chk("rst_writedata", bus.writedata, 0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Reset in the middle of a stalled load: strobes drop at once, no response
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd2;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h500;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid_memread", bus.memread, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_memread", bus.memread, 0);
    chk("async_be", bus.be, 0);
    chk("async_req_ready", bus.req_ready, 1);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_rsp", bus.rsp_valid, 0);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_rsp", bus.rsp_valid, 0);
    end
    run_vec(vecs[5]);
    run_vec(vecs[0]);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
